apb4_slave_bridge: RTL

Parametrised successor to the combinational APB slave converter. It terminates an APB4 slave port (pready, pslverr, pstrb) and converts each transfer into a single request/acknowledge transaction towards a peripheral register backend. Unlike the combinational converter, it adds:
- backend-driven wait states
- address range and alignment checking
- a bus-hang timeout that returns an error

It sits between the APB interconnect and every peripheral's register file.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_timeout_cnt.sv | 41 ++++
 rtl/apb4_slave_bridge.sv | 139 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB4 slave bridge.
//   apb_br_state_e : bridge FSM states
//   apb_resp_t     : latched APB response (read data + error flag)
//   bytes_of()     : bytes per data word for a given data width
package apb_pkg;

  // Widest supported data bus; the response struct is sized for it.
  localparam int unsigned RESP_DW   = 32;
  localparam int unsigned BYTES     = RESP_DW / 8;
  localparam int unsigned ALIGN_LSB = $clog2(BYTES);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitAck,
    StDone
  } apb_br_state_e;

  typedef struct packed {
    logic [RESP_DW-1:0] data;
    logic               err;
  } apb_resp_t;

  function automatic int unsigned bytes_of(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-cycle counter for the APB bridge.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count from zero
//   en       : count this cycle
//   expired  : high in the cycle that would make the count reach TIMEOUT_CYCLES
// With TIMEOUT_CYCLES = 0 the counter is absent and expired is constant 0.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, clr, en};
    assign expired   = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // Fires on the last counted cycle so the response lands exactly
    // TIMEOUT_CYCLES cycles after the request cycle.
    assign expired = en && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/apb4_slave_bridge.sv
// APB4 slave to request/acknowledge register-backend bridge.
//   APB side : psel, penable, pwrite, paddr, pwdata, pstrb -> prdata, pready, pslverr
//   Backend  : be_req pulse with be_we/be_addr/be_wdata/be_wstrb held until the next
//              request; be_ack pulse returns be_rdata/be_err.
// Adds backend wait states, address range/alignment errors and a hang timeout.
// All outputs are registered.
module apb4_slave_bridge #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_SPACE     = 256,
  parameter int unsigned ALIGN_CHECK    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    be_req,
  output logic                    be_we,
  output logic [ADDR_WIDTH-1:0]   be_addr,
  output logic [DATA_WIDTH-1:0]   be_wdata,
  output logic [DATA_WIDTH/8-1:0] be_wstrb,
  input  logic                    be_ack,
  input  logic [DATA_WIDTH-1:0]   be_rdata,
  input  logic                    be_err
);
  import apb_pkg::*;

  localparam int unsigned StrbW = bytes_of(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LowMask = ADDR_WIDTH'(StrbW - 1);

  apb_br_state_e state_q, state_d;
  apb_resp_t     resp_q, resp_d;

  logic                  addr_bad;
  logic                  capture;
  logic                  cnt_en;
  logic                  timed_out;
  logic                  pready_d;
  logic                  pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;

  assign addr_bad = (32'(paddr) >= 32'(ADDR_SPACE)) ||
                    ((ALIGN_CHECK != 0) && ((paddr & LowMask) != '0));

  assign cnt_en = (state_q == StReq) || (state_q == StWaitAck);

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (capture),
    .en     (cnt_en),
    .expired(timed_out)
  );

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          if (addr_bad) begin
            state_d = StDone;
            resp_d  = '{data: '0, err: 1'b1};
          end else begin
            state_d = StReq;
            capture = 1'b1;
          end
        end
      end
      StReq, StWaitAck: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (be_ack) begin
          state_d     = StDone;
          resp_d.err  = be_err;
          resp_d.data = (be_we || be_err) ? '0 : RESP_DW'(be_rdata);
        end else if (timed_out) begin
          state_d = StDone;
          resp_d  = '{data: '0, err: 1'b1};
        end else begin
          state_d = StWaitAck;
        end
      end
      StDone: begin
        // Leave only once the master has actually seen pready.
        if (!psel || (penable && pready)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Coming straight from IDLE (address error) the response is held back one
  // cycle so error transfers also show a single wait state.
  assign pready_d  = (state_d == StDone) && (state_q != StIdle);
  assign pslverr_d = pready_d && resp_d.err;
  assign prdata_d  = pready_d ? resp_d.data[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      resp_q   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      be_req   <= 1'b0;
      be_we    <= 1'b0;
      be_addr  <= '0;
      be_wdata <= '0;
      be_wstrb <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
      be_req  <= (state_d == StReq);
      if (capture) begin
        be_we    <= pwrite;
        be_addr  <= paddr & ~LowMask;
        be_wdata <= pwdata;
        be_wstrb <= pwrite ? pstrb : '0;
      end
    end
  end

endmodule
